writeback_regfile: RTL and testbench

Write-back end of the MEM/WB pipeline interface. It consumes the W-stage signals that the MEM/WB register produces and selects the final result, including load byte/halfword extraction and extension. It commits that result to a 32x32 general register file and serves two decode-stage read ports with same-cycle write bypass. It also drives the debug_wb_* trace signals used by the func-test trace comparator.

---
 rtl/writeback_regfile_pkg.sv | 23 ++
 rtl/writeback_regfile_if.sv | 41 ++++
 rtl/writeback_regfile_load_extract.sv | 35 +++
 rtl/writeback_regfile.sv | 91 +++++++++
 tb/tb_writeback_regfile.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_regfile_pkg.sv
// Shared widths, load-type encodings and reset constants for the write-back stage.
package writeback_regfile_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned PC_W       = 32;
   localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;
   localparam int unsigned CNT_W      = 32;

   localparam logic              RESETABLE = 1'b0;
   localparam logic [DATA_W-1:0] ZERO_WORD = '0;
   localparam logic [PC_W-1:0]   RESET_PC  = 32'hbfc0_0000;

   // Encodings 5-7 are not listed and fall back to a full-word load.
   typedef enum logic [2:0] {
      LtLw  = 3'd0,
      LtLb  = 3'd1,
      LtLbu = 3'd2,
      LtLh  = 3'd3,
      LtLhu = 3'd4
   } load_type_e;

endpackage

// File: rtl/writeback_regfile_if.sv
// W-stage bundle: MEM/WB register outputs in, decode read data and trace signals out.
interface writeback_regfile_if;
   import writeback_regfile_pkg::*;

   logic                  RegWriteW;
   logic                  MemtoRegW;
   logic                  HilotoRegW;
   logic                  PCtoRegW;
   logic [2:0]            LoadTypeW;
   logic [DATA_W-1:0]     ReadDataW;
   logic [DATA_W-1:0]     ALUOutW;
   logic [DATA_W-1:0]     HiloDataW;
   logic [PC_W-1:0]       PCPlus8W;
   logic [PC_W-1:0]       PCW;
   logic [REG_ADDR_W-1:0] WriteRegW;
   logic [REG_ADDR_W-1:0] ra1;
   logic [REG_ADDR_W-1:0] ra2;
   logic [DATA_W-1:0]     rd1;
   logic [DATA_W-1:0]     rd2;
   logic [DATA_W-1:0]     ResultW;
   logic [PC_W-1:0]       debug_wb_pc;
   logic [3:0]            debug_wb_rf_wen;
   logic [REG_ADDR_W-1:0] debug_wb_rf_wnum;
   logic [DATA_W-1:0]     debug_wb_rf_wdata;
   logic [CNT_W-1:0]      wb_commit_cnt;

   modport master (
      output RegWriteW, MemtoRegW, HilotoRegW, PCtoRegW, LoadTypeW, ReadDataW, ALUOutW,
             HiloDataW, PCPlus8W, PCW, WriteRegW, ra1, ra2,
      input  rd1, rd2, ResultW, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
             debug_wb_rf_wdata, wb_commit_cnt
   );

   modport slave (
      input  RegWriteW, MemtoRegW, HilotoRegW, PCtoRegW, LoadTypeW, ReadDataW, ALUOutW,
             HiloDataW, PCPlus8W, PCW, WriteRegW, ra1, ra2,
      output rd1, rd2, ResultW, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
             debug_wb_rf_wdata, wb_commit_cnt
   );

endinterface

// File: rtl/writeback_regfile_load_extract.sv
// Little-endian byte/halfword extraction and sign/zero extension of a loaded word.
module writeback_regfile_load_extract
   import writeback_regfile_pkg::*;
(
   input  logic [DATA_W-1:0] read_data_i,
   input  logic [1:0]        offset_i,
   input  logic [2:0]        load_type_i,
   output logic [DATA_W-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      unique case (offset_i)
         2'd0:    byte_sel = read_data_i[7:0];
         2'd1:    byte_sel = read_data_i[15:8];
         2'd2:    byte_sel = read_data_i[23:16];
         default: byte_sel = read_data_i[31:24];
      endcase
      // offset_i[0] is ignored: misaligned halfwords trap before reaching WB.
      half_sel = offset_i[1] ? read_data_i[31:16] : read_data_i[15:0];
   end

   always_comb begin
      case (load_type_e'(load_type_i))
         LtLb:    data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LtLbu:   data_o = {{(DATA_W-8){1'b0}}, byte_sel};
         LtLh:    data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
         LtLhu:   data_o = {{(DATA_W-16){1'b0}}, half_sel};
         default: data_o = read_data_i;
      endcase
   end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back result select, 32x32 register file with write-through read bypass,
// commit counter and func-test trace outputs.
module writeback_regfile
   import writeback_regfile_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   writeback_regfile_if.slave  wb
);

   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] result;
   logic              wr_en;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [CNT_W-1:0]  commit_cnt_q;
   logic [CNT_W-1:0]  commit_cnt_d;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   writeback_regfile_load_extract u_load_extract (
      .read_data_i (wb.ReadDataW),
      .offset_i    (wb.ALUOutW[1:0]),
      .load_type_i (wb.LoadTypeW),
      .data_o      (load_data)
   );

   always_comb begin
      if (wb.PCtoRegW) begin
         result = wb.PCPlus8W;
      end else if (wb.HilotoRegW) begin
         result = wb.HiloDataW;
      end else if (wb.MemtoRegW) begin
         result = load_data;
      end else begin
         result = wb.ALUOutW;
      end
   end

   assign wr_en        = (reset != RESETABLE) && wb.RegWriteW && (wb.WriteRegW != '0);
   assign commit_cnt_d = commit_cnt_q + {{(CNT_W-1){1'b0}}, wr_en};

   always_ff @(posedge clock) begin
      if (reset == RESETABLE) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= ZERO_WORD;
         end
         commit_cnt_q <= '0;
      end else begin
         if (wr_en) begin
            regs_q[wb.WriteRegW] <= result;
         end
         commit_cnt_q <= commit_cnt_d;
      end
   end

   // wr_en already excludes reset and $0, so the bypass inherits both rules.
   always_comb begin
      rd1 = regs_q[wb.ra1];
      if (wb.ra1 == '0) begin
         rd1 = ZERO_WORD;
      end else if (wr_en && (wb.WriteRegW == wb.ra1)) begin
         rd1 = result;
      end
      rd2 = regs_q[wb.ra2];
      if (wb.ra2 == '0) begin
         rd2 = ZERO_WORD;
      end else if (wr_en && (wb.WriteRegW == wb.ra2)) begin
         rd2 = result;
      end
   end

   assign wb.rd1           = rd1;
   assign wb.rd2           = rd2;
   assign wb.ResultW       = result;
   assign wb.wb_commit_cnt = commit_cnt_q;

   always_comb begin
      if (reset == RESETABLE) begin
         wb.debug_wb_rf_wen   = 4'b0000;
         wb.debug_wb_pc       = RESET_PC;
         wb.debug_wb_rf_wnum  = '0;
         wb.debug_wb_rf_wdata = ZERO_WORD;
      end else begin
         wb.debug_wb_rf_wen   = {4{wr_en}};
         wb.debug_wb_pc       = wb.PCW;
         wb.debug_wb_rf_wnum  = wb.WriteRegW;
         wb.debug_wb_rf_wdata = result;
      end
   end

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench: driver pushes expected per-cycle outputs from a behavioural model,
// a monitor pops and compares them against the DUT.
module tb_writeback_regfile;

   typedef struct {
      bit        rst_n;
      bit        we;
      bit        m2r;
      bit        h2r;
      bit        p2r;
      bit [2:0]  lt;
      bit [31:0] rdata;
      bit [31:0] alu;
      bit [31:0] hilo;
      bit [31:0] pc8;
      bit [31:0] pc;
      bit [4:0]  wreg;
      bit [4:0]  ra1;
      bit [4:0]  ra2;
   } stim_t;

   typedef struct {
      int        cyc;
      bit [31:0] rd1;
      bit [31:0] rd2;
      bit [31:0] res;
      bit [31:0] pc;
      bit [3:0]  wen;
      bit [4:0]  wnum;
      bit [31:0] wdata;
      bit [31:0] cnt;
   } exp_t;

   logic clk;
   logic rst_n;
   writeback_regfile_if wbif ();

   writeback_regfile dut (
      .clock (clk),
      .reset (rst_n),
      .wb    (wbif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t      expq[$];
   bit [31:0] mregs[32];
   bit [31:0] mcnt;
   int        checks;
   int        errors;
   int        cyc_n;

   task automatic chk(input string name, input int cyc, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle is an output cycle; compare away from the clock edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         while (expq.size() > 0) begin
            e = expq.pop_front();
            chk("rd1", e.cyc, wbif.rd1, e.rd1);
            chk("rd2", e.cyc, wbif.rd2, e.rd2);
            chk("ResultW", e.cyc, wbif.ResultW, e.res);
            chk("debug_wb_pc", e.cyc, wbif.debug_wb_pc, e.pc);
            chk("debug_wb_rf_wen", e.cyc, {28'd0, wbif.debug_wb_rf_wen}, {28'd0, e.wen});
            chk("debug_wb_rf_wnum", e.cyc, {27'd0, wbif.debug_wb_rf_wnum}, {27'd0, e.wnum});
            chk("debug_wb_rf_wdata", e.cyc, wbif.debug_wb_rf_wdata, e.wdata);
            chk("wb_commit_cnt", e.cyc, wbif.wb_commit_cnt, e.cnt);
         end
      end
   end

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      s.rst_n = 1'b1;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst_n = 1'b1;
      s.we    = ($urandom_range(3) != 0);
      s.m2r   = $urandom_range(1) == 1;
      s.h2r   = $urandom_range(3) == 0;
      s.p2r   = $urandom_range(3) == 0;
      s.lt    = 3'($urandom_range(7));
      s.rdata = $urandom;
      s.alu   = $urandom;
      s.hilo  = $urandom;
      s.pc8   = $urandom;
      s.pc    = $urandom;
      s.wreg  = 5'($urandom_range(31));
      s.ra1   = ($urandom_range(2) == 0) ? s.wreg : 5'($urandom_range(31));
      s.ra2   = ($urandom_range(2) == 0) ? s.wreg : 5'($urandom_range(31));
      return s;
   endfunction

   // Loaded value built from byte lanes with signed integer arithmetic.
   function automatic bit [31:0] model_load(input bit [31:0] word, input bit [1:0] off,
                                            input bit [2:0] lt);
      int unsigned b;
      int unsigned h;
      int          v;
      b = (word >> (8 * off)) & 32'hff;
      h = (off >= 2) ? (word >> 16) : (word & 32'hffff);
      case (lt)
         3'd1:    begin v = int'(b); if (b >= 128) v = v - 256; return 32'(v); end
         3'd2:    return 32'(b);
         3'd3:    begin v = int'(h); if (h >= 32768) v = v - 65536; return 32'(v); end
         3'd4:    return 32'(h);
         default: return word;
      endcase
   endfunction

   function automatic bit [31:0] model_result(input stim_t s);
      if (s.p2r) return s.pc8;
      if (s.h2r) return s.hilo;
      if (s.m2r) return model_load(s.rdata, s.alu[1:0], s.lt);
      return s.alu;
   endfunction

   function automatic bit [31:0] model_read(input stim_t s, input bit [4:0] ra,
                                            input bit [31:0] r);
      if (ra == 0) return 32'd0;
      if (s.rst_n && s.we && s.wreg == ra) return r;
      return mregs[ra];
   endfunction

   task automatic drive(input stim_t s);
      rst_n           = s.rst_n;
      wbif.RegWriteW  = s.we;
      wbif.MemtoRegW  = s.m2r;
      wbif.HilotoRegW = s.h2r;
      wbif.PCtoRegW   = s.p2r;
      wbif.LoadTypeW  = s.lt;
      wbif.ReadDataW  = s.rdata;
      wbif.ALUOutW    = s.alu;
      wbif.HiloDataW  = s.hilo;
      wbif.PCPlus8W   = s.pc8;
      wbif.PCW        = s.pc;
      wbif.WriteRegW  = s.wreg;
      wbif.ra1        = s.ra1;
      wbif.ra2        = s.ra2;
   endtask

   task automatic cycle(input stim_t s);
      exp_t      e;
      bit [31:0] r;
      @(negedge clk);
      drive(s);
      r     = model_result(s);
      e.cyc = cyc_n;
      e.res = r;
      e.rd1 = model_read(s, s.ra1, r);
      e.rd2 = model_read(s, s.ra2, r);
      e.cnt = mcnt;
      if (!s.rst_n) begin
         e.wen = 4'h0; e.pc = 32'hbfc0_0000; e.wnum = 5'd0; e.wdata = 32'd0;
      end else begin
         e.wen = (s.we && s.wreg != 0) ? 4'hF : 4'h0;
         e.pc = s.pc; e.wnum = s.wreg; e.wdata = r;
      end
      expq.push_back(e);
      cyc_n++;
      if (!s.rst_n) begin
         foreach (mregs[i]) mregs[i] = 32'd0;
         mcnt = 32'd0;
      end else if (s.we && s.wreg != 0) begin
         mregs[s.wreg] = r;
         mcnt          = mcnt + 32'd1;
      end
   endtask

   task automatic load_case(input bit [2:0] lt, input bit [1:0] off);
      stim_t s;
      s       = idle();
      s.we    = 1'b1;
      s.m2r   = 1'b1;
      s.lt    = lt;
      s.rdata = 32'h80FF_7F01;
      s.alu   = {30'h0400_0000, off};
      s.wreg  = 5'd7;
      s.ra1   = 5'd7;
      s.ra2   = 5'd7;
      cycle(s);
   endtask

   initial begin
      stim_t s;
      checks = 0;
      errors = 0;
      cyc_n  = 0;
      mcnt   = 32'd0;
      foreach (mregs[i]) mregs[i] = 32'd0;
      s       = idle();
      s.rst_n = 1'b0;
      drive(s);
      cycle(s);

      // Fill every register, then hold reset for two cycles with a write pending.
      for (int i = 1; i < 32; i++) begin
         s = idle(); s.we = 1'b1; s.wreg = 5'(i); s.alu = $urandom;
         s.ra1 = 5'(i); s.ra2 = 5'(32 - i);
         cycle(s);
      end
      for (int i = 0; i < 2; i++) begin
         s = idle(); s.rst_n = 1'b0; s.we = 1'b1; s.wreg = 5'd3; s.alu = 32'h5555_AAAA;
         s.ra1 = 5'd3; s.ra2 = 5'd31;
         cycle(s);
      end
      for (int i = 1; i < 32; i += 2) begin
         s = idle(); s.ra1 = 5'(i); s.ra2 = 5'(i + 1);
         cycle(s);
      end

      // Bypass, then storage, for a single ALU write.
      s = idle(); s.we = 1'b1; s.wreg = 5'd5; s.alu = 32'h1234_5678; s.ra1 = 5'd5; s.ra2 = 5'd5;
      cycle(s);
      s = idle(); s.ra1 = 5'd5; s.ra2 = 5'd0;
      cycle(s);

      for (int off = 0; off < 4; off++) begin
         load_case(3'd1, 2'(off));
         load_case(3'd2, 2'(off));
      end
      for (int off = 0; off < 4; off += 2) begin
         load_case(3'd3, 2'(off));
         load_case(3'd4, 2'(off));
      end
      load_case(3'd6, 2'd3);

      // $0 write is dropped; full select priority.
      s = idle(); s.we = 1'b1; s.wreg = 5'd0; s.alu = 32'hDEAD_BEEF;
      cycle(s);
      s = idle(); s.we = 1'b1; s.wreg = 5'd8; s.p2r = 1'b1; s.h2r = 1'b1; s.m2r = 1'b1;
      s.pc8 = 32'hbfc0_0008; s.hilo = 32'h1111_2222; s.rdata = 32'h3333_4444;
      s.alu = 32'h5555_6664; s.ra1 = 5'd8; s.ra2 = 5'd8;
      cycle(s);

      // Counter wrap: preload the next-state value for one edge.
      s = idle(); s.ra1 = 5'd8;
      @(negedge clk);
      drive(s);
      begin
         exp_t e;
         e.cyc = cyc_n; e.res = 32'd0; e.rd1 = mregs[8]; e.rd2 = 32'd0;
         e.pc = 32'd0; e.wen = 4'h0; e.wnum = 5'd0; e.wdata = 32'd0; e.cnt = mcnt;
         expq.push_back(e);
         cyc_n++;
      end
      force dut.commit_cnt_d = 32'hFFFF_FFFF;
      mcnt = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 release dut.commit_cnt_d;
      s = idle(); s.we = 1'b1; s.wreg = 5'd9; s.alu = 32'hCAFE_0001; s.ra1 = 5'd9;
      cycle(s);
      s = idle(); s.ra1 = 5'd9;
      cycle(s);

      // Reset mid-stream with a write pending.
      s = idle(); s.rst_n = 1'b0; s.we = 1'b1; s.wreg = 5'd9; s.alu = 32'h0BAD_0BAD;
      s.ra1 = 5'd9; s.ra2 = 5'd5;
      cycle(s);
      s = idle(); s.ra1 = 5'd9; s.ra2 = 5'd5;
      cycle(s);

      for (int i = 0; i < 300; i++) begin
         s = rand_stim();
         if ($urandom_range(39) == 0) s.rst_n = 1'b0;
         cycle(s);
      end

      @(negedge clk);
      #4;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
